// File: rtl/hack_cpu_pkg.sv
// Shared types and field positions for the multi-cycle Hack core.
// The instruction-type bit is always the MSB of the word, i.e. DATA_W-1.
package hack_cpu_pkg;

  typedef enum logic [2:0] {
    StResetIdle,
    StFetch,
    StDecode,
    StMread,
    StExec,
    StMwrite,
    StHalt
  } state_e;

  localparam logic [2:0] JmpNever  = 3'b000;
  localparam logic [2:0] JmpGt     = 3'b001;
  localparam logic [2:0] JmpEq     = 3'b010;
  localparam logic [2:0] JmpGe     = 3'b011;
  localparam logic [2:0] JmpLt     = 3'b100;
  localparam logic [2:0] JmpNe     = 3'b101;
  localparam logic [2:0] JmpLe     = 3'b110;
  localparam logic [2:0] JmpAlways = 3'b111;

  localparam int unsigned CBitFromMsb = 0;
  localparam int unsigned ABit        = 12;
  localparam int unsigned CompHi      = 11;
  localparam int unsigned CompLo      = 6;
  localparam int unsigned DestABit    = 5;
  localparam int unsigned DestDBit    = 4;
  localparam int unsigned DestMBit    = 3;
  localparam int unsigned JumpHi      = 2;
  localparam int unsigned JumpLo      = 0;

  function automatic logic jump_taken(logic [2:0] jmp, logic zr, logic ng);
    logic taken;
    case (jmp)
      JmpNever:  taken = 1'b0;
      JmpGt:     taken = !zr && !ng;
      JmpEq:     taken = zr;
      JmpGe:     taken = !ng;
      JmpLt:     taken = ng;
      JmpNe:     taken = !zr;
      JmpLe:     taken = zr || ng;
      JmpAlways: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/hack_cpu_mc_if.sv
// Instruction and data memory request/acknowledge bus of the multi-cycle Hack core.
interface hack_cpu_mc_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 15
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;
  logic              dmem_rd;
  logic              dmem_wr;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
    input  imem_ack, imem_data, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
    output imem_ack, imem_data, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/hack_alu_w.sv
// Combinational Hack ALU (zx/nx/zy/ny/f/no) at a configurable width.
module hack_alu_w #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [5:0]        comp_i,
  output logic [DATA_W-1:0] out_o
);
  logic [DATA_W-1:0] x, y, f;

  always_comb begin
    x = comp_i[5] ? '0 : x_i;
    if (comp_i[4]) x = ~x;
    y = comp_i[3] ? '0 : y_i;
    if (comp_i[2]) y = ~y;
    f     = comp_i[1] ? (x + y) : (x & y);
    out_o = comp_i[0] ? ~f : f;
  end
endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked instruction/data memory ports.
// Optional HALT state on a self-jump is enabled by defining HACK_CPU_HALT_EN.
module hack_cpu_mc
  import hack_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  hack_cpu_mc_if.master     bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, d_q, d_d, r_q, r_d, m_q, m_d;
  logic              zr_q, zr_d, ng_q, ng_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              imem_req_q, dmem_rd_q, dmem_wr_q;

  logic [DATA_W-1:0] alu_out, commit_res;
  logic [ADDR_W-1:0] pc_inc, a_tgt;
  logic              commit, taken, commit_zr, commit_ng;

  wire       is_c   = ir_q[DATA_W-1-CBitFromMsb];
  wire       a_bit  = ir_q[ABit];
  wire [2:0] dest   = {ir_q[DestABit], ir_q[DestDBit], ir_q[DestMBit]};
  wire [2:0] jmp    = ir_q[JumpHi:JumpLo];

  hack_alu_w #(.DATA_W(DATA_W)) u_alu (
    .x_i    (d_q),
    .y_i    (a_bit ? m_q : a_q),
    .comp_i (ir_q[CompHi:CompLo]),
    .out_o  (alu_out)
  );

  assign pc_inc = pc_q + 1'b1;
  assign a_tgt  = a_q[ADDR_W-1:0];

  // Commit happens either straight out of EXEC (result not yet in R) or after MWRITE.
  assign commit_res = (state_q == StExec) ? alu_out : r_q;
  assign commit_zr  = (state_q == StExec) ? (alu_out == '0) : zr_q;
  assign commit_ng  = (state_q == StExec) ? alu_out[DATA_W-1] : ng_q;
  assign taken      = jump_taken(jmp, commit_zr, commit_ng);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    d_d     = d_q;
    r_d     = r_q;
    m_d     = m_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    pc_d    = pc_q;
    commit  = 1'b0;
    case (state_q)
      StResetIdle: state_d = StFetch;
      StFetch: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!is_c) begin
          a_d     = {1'b0, ir_q[DATA_W-2:0]};
          pc_d    = pc_inc;
          state_d = StFetch;
        end else begin
          state_d = a_bit ? StMread : StExec;
        end
      end
      StMread: begin
        if (bus.dmem_ack) begin
          m_d     = bus.dmem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        r_d  = alu_out;
        zr_d = (alu_out == '0);
        ng_d = alu_out[DATA_W-1];
        if (dest[0]) state_d = StMwrite;
        else         commit  = 1'b1;
      end
      StMwrite: commit = bus.dmem_ack;
      StHalt:   state_d = StHalt;
      default:  state_d = StResetIdle;
    endcase
    if (commit) begin
      if (dest[1]) d_d = commit_res;
      if (dest[2]) a_d = commit_res;
      pc_d    = taken ? a_tgt : pc_inc;
      state_d = StFetch;
`ifdef HACK_CPU_HALT_EN
      if (state_q == StExec && dest == 3'b000 && taken && a_tgt == pc_q) state_d = StHalt;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StResetIdle;
      ir_q       <= '0;
      a_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      m_q        <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
      pc_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_rd_q  <= 1'b0;
      dmem_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      d_q        <= d_d;
      r_q        <= r_d;
      m_q        <= m_d;
      zr_q       <= zr_d;
      ng_q       <= ng_d;
      pc_q       <= pc_d;
      imem_req_q <= (state_d == StFetch);
      dmem_rd_q  <= (state_d == StMread);
      dmem_wr_q  <= (state_d == StMwrite);
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_rd    = dmem_rd_q;
  assign bus.dmem_wr    = dmem_wr_q;
  assign bus.dmem_addr  = a_tgt;
  assign bus.dmem_wdata = r_q;
  assign pc             = pc_q;

`ifdef HACK_CPU_HALT_EN
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed testbench for hack_cpu_mc: a 16-bit core on a wait-stated memory model
// plus a 24-bit core exercising the wide immediate and PC wrap.
module tb_hack_cpu_mc;
  logic clk, reset_n;
  logic [14:0] pc, pc24;
  logic halted, halted24;

  hack_cpu_mc_if #(.DATA_W(16), .ADDR_W(15)) bus ();
  hack_cpu_mc_if #(.DATA_W(24), .ADDR_W(15)) bus24 ();

  hack_cpu_mc #(.DATA_W(16), .ADDR_W(15)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .pc(pc), .halted(halted)
  );
  hack_cpu_mc #(.DATA_W(24), .ADDR_W(15)) u_dut24 (
    .clk(clk), .reset_n(reset_n), .bus(bus24), .pc(pc24), .halted(halted24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit memory model: zero-wait ROM, RAM with dlat wait cycles.
  logic [15:0] imem [0:63];
  logic [15:0] dmem [0:255];
  logic [3:0]  dcnt, dlat;
  logic        dack_force, dack_n;
  int          dact, overlap;

  assign bus.imem_ack   = bus.imem_req;
  assign bus.imem_data  = imem[bus.imem_addr[5:0]];
  assign bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];
  assign dack_n         = (bus.dmem_rd || bus.dmem_wr) && (dcnt == dlat);
  assign bus.dmem_ack   = dack_n || dack_force;

  always @(posedge clk) begin
    if (!(bus.dmem_rd || bus.dmem_wr) || dack_n) dcnt <= 4'd0;
    else                                         dcnt <= dcnt + 4'd1;
    if (bus.dmem_wr && bus.dmem_ack) dmem[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
    if (reset_n && (bus.dmem_rd || bus.dmem_wr)) dact <= dact + 1;
    if (bus.dmem_rd && bus.dmem_wr) overlap <= overlap + 1;
  end

  // 24-bit core: jump to 0x7FFF and run an A-instruction there.
  assign bus24.imem_ack   = bus24.imem_req;
  assign bus24.dmem_ack   = bus24.dmem_rd || bus24.dmem_wr;
  assign bus24.dmem_rdata = 24'h0;
  always_comb begin
    case (bus24.imem_addr)
      15'h0000: bus24.imem_data = 24'h007FFF;
      15'h0001: bus24.imem_data = 24'hFFEA87;
      15'h7FFF: bus24.imem_data = 24'h123456;
      default:  bus24.imem_data = 24'h000000;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst_pc", {17'h0, pc}, 32'h0);
    check_eq("rst_req", {29'h0, bus.imem_req, bus.dmem_rd, bus.dmem_wr}, 32'h0);
    check_eq("rst_wdata", {16'h0, bus.dmem_wdata}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  localparam logic [15:0] JvSet [5] = '{16'hEA90, 16'hEFD0, 16'hEE90, 16'hEFD0, 16'hEA90};
  localparam logic [15:0] JvJmp [5] = '{16'hE302, 16'hE302, 16'hE304, 16'hE301, 16'hE305};
  localparam logic [14:0] JvPc  [5] = '{15'd42, 15'd3, 15'd42, 15'd42, 15'd3};

  int base, n, fetch3;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic seen;

  initial begin
    reset_n = 1'b0; dlat = 4'd0; dack_force = 1'b0; dcnt = 4'd0; dact = 0; overlap = 0;
    clear_prog();
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;

    // @5 ; D=A
    imem[0] = 16'h0005; imem[1] = 16'hEC10;
    do_reset();
    check_eq("rst_halted", {31'h0, halted}, 32'h0);
    check_eq("rst_a", {16'h0, u_dut.a_q}, 32'h0);
    base = dact;
    step(1);
    check_eq("first_fetch", {16'h0, bus.imem_req, bus.imem_addr}, {16'h0, 1'b1, 15'd0});
    step(5);
    check_eq("dA_d", {16'h0, u_dut.d_q}, 32'd5);
    check_eq("dA_pc", {17'h0, pc}, 32'd2);
    check_eq("dA_no_dmem", dact - base, 0);

    // @7 ; D=A ; @100 ; M=D+1 (write waits 3) ; D=M
    clear_prog();
    imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0064;
    imem[3] = 16'hE7C8; imem[4] = 16'hFC10;
    dlat = 4'd3;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.dmem_wr;
    end
    check_eq("wr_seen", {31'h0, seen}, 32'h1);
    wr_addr = bus.dmem_addr; wr_data = bus.dmem_wdata;
    n = 0;
    while (bus.dmem_wr && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_eq("wr_hold", n, 4);
    check_eq("wr_addr", {17'h0, wr_addr}, 32'd100);
    check_eq("wr_data", {16'h0, wr_data}, 32'd8);
    check_eq("wr_then_fetch", {16'h0, bus.imem_req, pc}, {16'h0, 1'b1, 15'd4});
    for (int i = 0; i < 40 && pc != 15'd5; i++) step(1);
    check_eq("rd_pc", {17'h0, pc}, 32'd5);
    check_eq("rd_d", {16'h0, u_dut.d_q}, 32'd8);
    check_eq("ram_100", {16'h0, dmem[100]}, 32'd8);

    // Dset ; @42 ; D;Jxx
    dlat = 4'd0;
    for (int v = 0; v < 5; v++) begin
      clear_prog();
      imem[0] = JvSet[v]; imem[1] = 16'h002A; imem[2] = JvJmp[v];
      do_reset();
      step(8);
      check_eq($sformatf("jmp%0d_pre", v), {17'h0, pc}, 32'd2);
      step(1);
      check_eq($sformatf("jmp%0d_pc", v), {17'h0, pc}, {17'h0, JvPc[v]});
    end

    // 24-bit core: wrap from 0x7FFF and the 23-bit immediate
    do_reset();
    step(5);
    check_eq("w24_pc1", {17'h0, pc24}, 32'd1);
    step(1);
    check_eq("w24_pc7fff", {17'h0, pc24}, 32'h7FFF);
    step(2);
    check_eq("w24_wrap", {17'h0, pc24}, 32'h0);
    check_eq("w24_a", {8'h0, u_dut24.a_q}, 32'h123456);

    // Reset during an outstanding read, then a stray ack
    clear_prog();
    imem[0] = 16'h0064; imem[1] = 16'hFC10;
    dlat = 4'd5;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.dmem_rd;
    end
    check_eq("rd_seen", {31'h0, seen}, 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_rd", {31'h0, bus.dmem_rd}, 32'h0);
    check_eq("midrst_pc", {17'h0, pc}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dack_force = 1'b1;
    step(3);
    dack_force = 1'b0;
    check_eq("stray_pc", {17'h0, pc}, 32'd1);
    check_eq("stray_d", {16'h0, u_dut.d_q}, 32'h0);
    check_eq("stray_fetch", {31'h0, bus.imem_req}, 32'h1);

    // @0 ; @0 ; @3 ; 0;JMP  (self-jump at pc 3)
    dlat = 4'd0;
    clear_prog();
    imem[2] = 16'h0003; imem[3] = 16'hEA87;
    do_reset();
    step(10);
    fetch3 = 0;
    for (int i = 0; i < 9; i++) begin
      if (bus.imem_req && bus.imem_addr == 15'd3) fetch3++;
      step(1);
    end
    check_eq("loop_pc", {17'h0, pc}, 32'd3);
`ifdef HACK_CPU_HALT_EN
    check_eq("halt_flag", {31'h0, halted}, 32'h1);
    check_eq("halt_fetches", fetch3, 0);
`else
    check_eq("halt_flag", {31'h0, halted}, 32'h0);
    check_eq("loop_fetches", fetch3, 3);
`endif
    check_eq("rd_wr_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hack_cpu_mc.md
# hack_cpu_mc

Parametrised, multi-cycle successor to the single-cycle Hack core. It runs the Hack A/C instruction set at a configurable data width. Instruction fetch and data-memory access go over separate request/acknowledge ports, so the core can sit behind wait-stated ROM and RAM rather than ideal zero-latency memories. A small FSM sequences fetch, decode, optional memory read, execute and optional memory write.

## Interface
- `DATA_W`, default 16: datapath and register width; must be ≥ 16.
- `ADDR_W`, default 15: instruction and data address width; must be ≤ `DATA_W`-1.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: instruction fetch request, held high until acknowledged.
- `imem_addr` out `ADDR_W`: fetch address, equal to `pc`.
- `imem_ack` in 1: fetch acknowledge; `imem_data` is valid in the same cycle.
- `imem_data` in `DATA_W`: instruction word.
- `dmem_rd` out 1: data read request, held high until acknowledged.
- `dmem_wr` out 1: data write request, held high until acknowledged.
- `dmem_addr` out `ADDR_W`: `A[ADDR_W-1:0]`.
- `dmem_wdata` out `DATA_W`: latched ALU result.
- `dmem_rdata` in `DATA_W`: read data, valid with `dmem_ack`.
- `dmem_ack` in 1: data acknowledge.
- `pc` out `ADDR_W`: address of the current instruction.
- `halted` out 1: core has stopped (see Configuration).

## Operation
- **Instruction format**
  - Bit `DATA_W`-1 = 0: A-instruction. A ← `{1'b0, imem_data[DATA_W-2:0]}`.
  - Bit `DATA_W`-1 = 1: C-instruction. Fields: a-bit [12], comp [11:6], dest [5:3] (A, D, M), jump [2:0].
  - Bits [`DATA_W`-2:13] of a C-instruction are ignored.
- **States**: RESET_IDLE, FETCH, DECODE, MREAD, EXEC, MWRITE, HALT.
- **FETCH**: drive `imem_req`=1; on `imem_ack`, latch IR and go to DECODE.
- **DECODE**
  - A-instruction: load A, PC ← PC+1, go to FETCH.
  - C-instruction with a=1: go to MREAD.
  - Otherwise: go to EXEC.
- **MREAD**: drive `dmem_rd`=1; on `dmem_ack`, latch `dmem_rdata` into M-latch and go to EXEC.
- **EXEC**
  - ALU inputs: x = D; y = a ? M-latch : A. Standard Hack zx/nx/zy/ny/f/no, result width `DATA_W`.
  - Latch the result into R, plus zr (R==0) and ng (R[`DATA_W`-1]).
  - If dest M: go to MWRITE. Otherwise commit and go to FETCH.
- **MWRITE**: drive `dmem_wr`=1 with `dmem_wdata`=R and address = old A. On `dmem_ack`, commit and go to FETCH.
- **Commit** (single edge)
  - D ← R if dest D.
  - A ← R if dest A.
  - PC ← A_old if jump taken, else PC+1.
  - All reads use pre-commit A and D.
- **Jump condition** on zr/ng:
  - 000 never, 001 GT, 010 EQ, 011 GE, 100 LT, 101 NE, 110 LE, 111 always.
- **Arithmetic**: PC+1 wraps modulo 2^`ADDR_W`. The jump target and `dmem_addr` use A truncated to `ADDR_W`.
- **Handshake rules**
  - `imem_ack`/`dmem_ack` received outside the matching request state is ignored.
  - Requests never drop before their ack arrives.
  - `dmem_rd` and `dmem_wr` are never high together.

## Timing
- **Reset values** (`reset_n` low, asynchronous): A=D=R=0, `pc`=0, IR=0.
  - All requests are 0, `dmem_wdata`=0, `halted`=0, state = RESET_IDLE.
- First `clk` edge after `reset_n` rises: RESET_IDLE → FETCH.
- **Cycles per instruction** with zero-wait ack (ack in the same cycle as request):
  - A-instruction: 2.
  - C-instruction, a=0, no M write: 3.
  - Add 1 for the M read and 1 for the M write. Each wait cycle adds 1.
- Reset asserted mid-transaction: requests fall immediately and combinationally; the outstanding ack is not awaited.

## Configuration
- **`HACK_CPU_HALT_EN` defined**
  - In EXEC, a C-instruction with dest=000, a taken jump and A_old == PC enters HALT.
  - In HALT: `halted`=1, no further requests, `pc` frozen. Only reset exits.
- **Macro undefined**: HALT does not exist, such a jump loops forever, and `halted` is tied 0.

## Structure
- **Package `hack_cpu_pkg`**:
  - state enum;
  - jump-code constants;
  - field-position localparams (C bit, a-bit, comp, dest, jump).
- **Sub-module `hack_alu_w`**: combinational ALU parametrised by `DATA_W`. The FSM, registers and handshakes stay in `hack_cpu_mc`.

## Test plan
- `@5`, then `D=A` with zero-wait acks → D=5, `pc`=2 after 5 cycles, no dmem activity.
- A=100, `M=D+1` with D=7, `dmem_ack` delayed 3 cycles on the write → `dmem_wr` held 4 cycles, addr=100, wdata=8, then FETCH.
- D=0, A=42, `D;JEQ` → `pc`=42. Same with D=1 → `pc`=PC+1.
- `DATA_W`=24, `ADDR_W`=15 at `pc`=0x7FFF, A-instruction → `pc` wraps to 0; A gets the 23-bit immediate.
- Assert `reset_n` low while `dmem_rd`=1 → `dmem_rd`=0 immediately, `pc`=0; a later stray `dmem_ack` is ignored.
- With `HACK_CPU_HALT_EN`: `@3` at `pc`=2, then `0;JMP` at `pc`=3 → `halted`=1, `imem_req` stays 0. Without the macro, fetches of address 3 repeat.
